// File: rtl/shift_rx8.sv
// rtl/shift_rx8.sv - serial-in/parallel-out receiver with valid/ready word output
module shift_rx8 #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic             s_in,
    input  logic             frame_clr,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             overrun_clr
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_nxt;
    logic [CW-1:0]    count_q, count_nxt;
    logic [WIDTH-1:0] sr_q, sr_nxt;
    logic [WIDTH-1:0] sr_shifted;
    logic [WIDTH-1:0] q_nxt;
    logic             q_valid_nxt;
    logic             overrun_nxt;
    logic             take_bit;
    logic             complete;
    logic             slot_free;
    logic             load_word;
    logic             drop_word;

    // Shift the incoming bit in from the side that matches the link's bit order
    always_comb begin
        sr_shifted = sr_q;
        if (MSB_FIRST) begin
            sr_shifted = {sr_q[WIDTH-2:0], s_in};
        end else begin
            sr_shifted = {s_in, sr_q[WIDTH-1:1]};
        end
    end

    // Word-completion and output-slot handshake decode; an abort suppresses completion
    always_comb begin
        take_bit  = s_valid && !frame_clr;
        complete  = take_bit && (count_q == LAST);
        slot_free = !q_valid || q_ready;
        load_word = complete && slot_free;
        drop_word = complete && !slot_free;
    end

    // Next-state: bit counter/FSM, shift register, output slot and sticky overrun
    always_comb begin
        state_nxt   = state_q;
        count_nxt   = count_q;
        sr_nxt      = sr_q;
        q_nxt       = q;
        q_valid_nxt = q_valid;
        overrun_nxt = overrun;

        if (frame_clr) begin
            count_nxt = '0;
            sr_nxt    = '0;
        end else if (s_valid) begin
            sr_nxt = sr_shifted;
            if (complete) begin
                count_nxt = '0;
            end else begin
                count_nxt = count_q + CW'(1);
            end
        end

        state_nxt = (count_nxt != '0) ? SHIFT : IDLE;

        if (load_word) begin
            q_nxt       = sr_shifted;
            q_valid_nxt = 1'b1;
        end else if (q_valid && q_ready) begin
            q_valid_nxt = 1'b0;
        end

        // A drop in the same cycle as a clear request keeps the flag set
        if (drop_word) begin
            overrun_nxt = 1'b1;
        end else if (overrun_clr) begin
            overrun_nxt = 1'b0;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            sr_q    <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_nxt;
            count_q <= count_nxt;
            sr_q    <= sr_nxt;
            q       <= q_nxt;
            q_valid <= q_valid_nxt;
            overrun <= overrun_nxt;
        end
    end

    assign busy = (state_q == SHIFT);

endmodule
